// File: rtl/abro_input_conditioner_pkg.sv
// rtl/abro_input_conditioner_pkg.sv - shared ABRO front-end defaults and types
package abro_input_conditioner_pkg;

   // Kept here so the ABRO state machine bench and this block agree on timing.
   localparam int ABRO_SYNC_STAGES     = 2;
   localparam int ABRO_DEBOUNCE_CYCLES = 4;
   localparam int ABRO_CNT_W           = 8;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'd0,
      EDGE_RISE = 2'd1,
      EDGE_FALL = 2'd2
   } edge_e;

endpackage

// File: rtl/abro_input_conditioner_channel.sv
// rtl/abro_input_conditioner_channel.sv - one input: synchroniser, debounce counter, clean level, edge pulses
module abro_debounce_channel
   import abro_input_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = ABRO_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = ABRO_DEBOUNCE_CYCLES,
   parameter int CNT_W           = ABRO_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic clean_o,
   output logic rise_o,
   output logic fall_o,
   output logic idle_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   clean_q, clean_d;
   edge_e                  edge_q, edge_d;
   logic                   sync_bit;

   assign sync_bit = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         clean_q <= 1'b0;
         edge_q  <= EDGE_NONE;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         edge_q  <= edge_d;
      end
   end

   // The pulse is registered alongside clean so both become visible on the same edge.
   always_comb begin
      cnt_d   = cnt_q;
      clean_d = clean_q;
      edge_d  = EDGE_NONE;
      if (sync_bit == clean_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d   = '0;
         clean_d = sync_bit;
         edge_d  = sync_bit ? EDGE_RISE : EDGE_FALL;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign clean_o = clean_q;
   assign rise_o  = (edge_q == EDGE_RISE);
   assign fall_o  = (edge_q == EDGE_FALL);
   assign idle_o  = (cnt_q == '0) && (sync_bit == clean_q);

endmodule

// File: rtl/abro_input_conditioner.sv
// rtl/abro_input_conditioner.sv - synchronises and debounces raw A/B pins for the ABRO state machine
module abro_input_conditioner
   import abro_input_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = ABRO_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = ABRO_DEBOUNCE_CYCLES,
   parameter int CNT_W           = ABRO_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic A_raw,
   input  logic B_raw,
   output logic A_clean,
   output logic B_clean,
   output logic A_rise,
   output logic B_rise,
   output logic A_fall,
   output logic B_fall,
   output logic settled
);

   logic a_idle, b_idle;

   abro_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_chan_a (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (A_raw),
      .clean_o(A_clean),
      .rise_o (A_rise),
      .fall_o (A_fall),
      .idle_o (a_idle)
   );

   abro_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_chan_b (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (B_raw),
      .clean_o(B_clean),
      .rise_o (B_rise),
      .fall_o (B_fall),
      .idle_o (b_idle)
   );

   assign settled = a_idle & b_idle;

endmodule

// File: tb/tb_abro_input_conditioner.sv
// tb/tb_abro_input_conditioner.sv - randomized scoreboard bench for abro_input_conditioner (default and swept parameters)
module tb_abro_input_conditioner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_raw = 1'b0;
   logic b_raw = 1'b0;
   logic a_clean [2];
   logic b_clean [2];
   logic a_rise  [2];
   logic b_rise  [2];
   logic a_fall  [2];
   logic b_fall  [2];
   logic settled [2];

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   abro_input_conditioner dut0 (
      .clk(clk), .rst(rst), .A_raw(a_raw), .B_raw(b_raw),
      .A_clean(a_clean[0]), .B_clean(b_clean[0]),
      .A_rise(a_rise[0]), .B_rise(b_rise[0]),
      .A_fall(a_fall[0]), .B_fall(b_fall[0]),
      .settled(settled[0])
   );

   abro_input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .A_raw(a_raw), .B_raw(b_raw),
      .A_clean(a_clean[1]), .B_clean(b_clean[1]),
      .A_rise(a_rise[1]), .B_rise(b_rise[1]),
      .A_fall(a_fall[1]), .B_fall(b_fall[1]),
      .settled(settled[1])
   );

   // Reference model: raw history per edge, with clean decided by a window rule.
   bit hist [2][0:2047];
   int n;
   bit m_clean [2][2];
   bit m_rise  [2][2];
   bit m_fall  [2][2];
   int m_last  [2][2];
   bit m_settled [2];

   function automatic int sync_len(int d);
      return (d == 0) ? 2 : 3;
   endfunction

   function automatic int deb_len(int d);
      return (d == 0) ? 4 : 1;
   endfunction

   // Synchronised value visible after edge k.
   function automatic bit sync_at(int d, int c, int k);
      int src;
      src = k - sync_len(d) + 1;
      return (src >= 1) ? hist[c][src] : 1'b0;
   endfunction

   task automatic model_reset();
      n = 0;
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 2; c++) begin
            m_clean[d][c] = 0; m_rise[d][c] = 0; m_fall[d][c] = 0; m_last[d][c] = 0;
         end
         m_settled[d] = 1;
      end
   endtask

   task automatic model_edge();
      bit old, upd, quiet;
      n++;
      hist[0][n] = a_raw;
      hist[1][n] = b_raw;
      for (int d = 0; d < 2; d++) begin
         m_settled[d] = 1;
         for (int c = 0; c < 2; c++) begin
            old = m_clean[d][c];
            upd = (n - m_last[d][c]) >= deb_len(d);
            for (int j = n - deb_len(d) + 1; j <= n; j++)
               if (sync_at(d, c, j - 1) == old) upd = 0;
            if (upd) begin
               m_clean[d][c] = ~old;
               m_last[d][c]  = n;
            end
            m_rise[d][c] = upd & m_clean[d][c];
            m_fall[d][c] = upd & ~m_clean[d][c];
            quiet = upd || (sync_at(d, c, n - 1) == old);
            if (!(quiet && (sync_at(d, c, n) == m_clean[d][c]))) m_settled[d] = 0;
         end
      end
   endtask

   task automatic drive_cycle(input string tag, input bit a, input bit b);
      logic [2:0] act;
      logic [2:0] exp;
      a_raw = a;
      b_raw = b;
      @(posedge clk);
      model_edge();
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 2; c++) begin
            act = (c == 0) ? {a_clean[d], a_rise[d], a_fall[d]} : {b_clean[d], b_rise[d], b_fall[d]};
            exp = {m_clean[d][c], m_rise[d][c], m_fall[d][c]};
            vectors++;
            if (act !== exp) begin
               errors++;
               $display("FAIL %s dut%0d ch%s edge%0d {clean,rise,fall} got %b exp %b",
                        tag, d, (c == 0) ? "A" : "B", n, act, exp);
            end
         end
         vectors++;
         if (settled[d] !== m_settled[d]) begin
            errors++;
            $display("FAIL %s dut%0d settled edge%0d got %b exp %b", tag, d, n, settled[d], m_settled[d]);
         end
      end
   endtask

   task automatic apply_reset();
      #2;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      a_raw = 1; b_raw = 1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         #1;
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({a_clean[d], b_clean[d], a_rise[d], b_rise[d], a_fall[d], b_fall[d], settled[d]} !== 7'b0000001) begin
               errors++;
               $display("FAIL reset_state dut%0d got %b exp 0000001", d,
                        {a_clean[d], b_clean[d], a_rise[d], b_rise[d], a_fall[d], b_fall[d], settled[d]});
            end
         end
         @(posedge clk);
      end
      #2;
      rst = 0;
      for (int k = 0; k < 8; k++) begin
         drive_cycle("reset_release", 1, 0);
         if (n == 6) begin
            vectors++;
            if ({a_clean[0], a_rise[0]} !== 2'b11) begin
               errors++;
               $display("FAIL release_edge6 {A_clean,A_rise} got %b exp 11", {a_clean[0], a_rise[0]});
            end
         end
         if (n == 7) begin
            vectors++;
            if ({a_clean[0], a_rise[0]} !== 2'b10) begin
               errors++;
               $display("FAIL release_edge7 {A_clean,A_rise} got %b exp 10", {a_clean[0], a_rise[0]});
            end
         end
      end
   endtask

   task automatic test_glitch();
      apply_reset();
      drive_cycle("glitch", 1, 0);
      drive_cycle("glitch", 1, 0);
      for (int k = 0; k < 8; k++) drive_cycle("glitch", 0, 0);
      vectors++;
      if ({a_clean[0], settled[0]} !== 2'b01) begin
         errors++;
         $display("FAIL glitch_final {A_clean,settled} got %b exp 01", {a_clean[0], settled[0]});
      end
   endtask

   task automatic test_threshold();
      apply_reset();
      for (int k = 0; k < 4; k++) drive_cycle("threshold", 1, 0);
      for (int k = 0; k < 10; k++) begin
         drive_cycle("threshold", 0, 0);
         if (n == 6 || n == 10) begin
            vectors++;
            if ({a_rise[0], a_fall[0]} !== ((n == 6) ? 2'b10 : 2'b01)) begin
               errors++;
               $display("FAIL threshold_pulse edge%0d {A_rise,A_fall} got %b", n, {a_rise[0], a_fall[0]});
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         drive_cycle("simultaneous", 1, 1);
         if (n == 6) begin
            vectors++;
            if ({a_rise[0], b_rise[0], a_clean[0] & b_clean[0]} !== 3'b111) begin
               errors++;
               $display("FAIL simultaneous_edge6 {A_rise,B_rise,O} got %b exp 111",
                        {a_rise[0], b_rise[0], a_clean[0] & b_clean[0]});
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int k = 0; k < 3; k++) drive_cycle("reset_mid", 0, 1);
      #2;
      rst = 1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         #1;
         for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({b_clean[d], b_rise[d], settled[d]} !== 3'b001) begin
               errors++;
               $display("FAIL reset_mid_hold dut%0d {B_clean,B_rise,settled} got %b exp 001",
                        d, {b_clean[d], b_rise[d], settled[d]});
            end
         end
         @(posedge clk);
      end
      #2;
      rst = 0;
      for (int k = 0; k < 10; k++) drive_cycle("reset_mid_after", 0, 0);
   endtask

   task automatic test_sweep();
      int rises, falls;
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         drive_cycle("sweep_step", 1, 0);
         if (n == 4) begin
            vectors++;
            if ({a_clean[1], a_rise[1]} !== 2'b11) begin
               errors++;
               $display("FAIL sweep_edge4 {A_clean,A_rise} got %b exp 11", {a_clean[1], a_rise[1]});
            end
         end
      end
      for (int k = 0; k < 6; k++) drive_cycle("sweep_low", 0, 0);
      rises = 0; falls = 0;
      drive_cycle("sweep_glitch", 1, 0);
      for (int k = 0; k < 6; k++) begin
         drive_cycle("sweep_glitch", 0, 0);
         rises += a_rise[1];
         falls += a_fall[1];
      end
      vectors++;
      if (rises != 1 || falls != 1) begin
         errors++;
         $display("FAIL sweep_glitch_pulses rises %0d falls %0d exp 1 and 1", rises, falls);
      end
   endtask

   task automatic test_random();
      bit a, b;
      int run;
      for (int blk = 0; blk < 3; blk++) begin
         apply_reset();
         a = 0; b = 0;
         for (int k = 0; k < 300; k++) begin
            run = $urandom_range(0, 9);
            if (run < 2) a = ~a;
            else if (run == 2) b = ~b;
            else if (run == 3) begin a = $urandom_range(0, 1); b = $urandom_range(0, 1); end
            drive_cycle("random", a, b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_threshold();
      test_simultaneous();
      test_reset_mid();
      test_sweep();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
